// File: rtl/piperam_var.sv
// piperam_var: runtime-programmable multi-channel RAM delay line.
//
// All lanes share one write/read pointer pair on a dual-port block RAM with
// a 2-cycle read latency. A fill counter keeps the output forced to zero
// until every lane holds a sample written in the current epoch.
//
// Optional build macro: PIPERAM_VAR_SHORT_EN
//   Defined   - two bypass registers serve delays 1 and 2; minimum delay is 1.
//   Undefined - RAM path only; requested delays below 3 clamp to 3.

// Simple dual-port RAM: one write port, one read port.
// Read data appears two clock edges after the read address is presented.
module ram_blk_dp #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_q1;
    logic [DW-1:0] r_q2;

    // Write every cycle; read-before-write when both ports hit one address.
    always_ff @(posedge clk) begin
        r_mem[i_waddr] <= i_wdata;
        r_q1           <= r_mem[i_raddr];
        r_q2           <= r_q1;
    end

    assign o_rdata = r_q2;
endmodule

module piperam_var #(
    parameter int MAX_DELAY  = 1024,
    parameter int WIDTH      = 16,
    parameter int CHANNELS   = 1,
    parameter int DELAY_INIT = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CHANNELS*WIDTH-1:0]        i,
    input  logic [$clog2(MAX_DELAY+1)-1:0]   delay,
    input  logic                             delay_ld,
    output logic [CHANNELS*WIDTH-1:0]        o,
    output logic                             o_valid,
    output logic [$clog2(MAX_DELAY+1)-1:0]   delay_cur
);
    localparam int DW = $clog2(MAX_DELAY + 1);
    localparam int AW = $clog2(MAX_DELAY);
    localparam int CW = CHANNELS * WIDTH;
`ifdef PIPERAM_VAR_SHORT_EN
    localparam int DMIN = 1;
`else
    localparam int DMIN = 3;
`endif

    // Force a requested delay into [DMIN, MAX_DELAY].
    function automatic logic [DW-1:0] f_clamp(input logic [DW-1:0] d);
        if (d < DW'(DMIN))
            return DW'(DMIN);
        else if (d > DW'(MAX_DELAY))
            return DW'(MAX_DELAY);
        else
            return d;
    endfunction

    logic [DW-1:0] r_delay;
    logic [DW-1:0] r_fill;
    logic          r_valid;
    logic [AW-1:0] r_wp;
    logic [DW-1:0] w_fill_next;
    logic [AW-1:0] w_rd_ofs;
    logic [AW-1:0] w_ra;
    logic [CW-1:0] w_ram_q;
    logic [CW-1:0] w_data;

    // Fill counter saturates at the delay in force.
    always_comb begin
        w_fill_next = r_fill;
        if (r_fill != r_delay)
            w_fill_next = r_fill + 1'b1;
    end

    // Read address leads the output by the RAM latency (2 cycles), so it
    // trails the write pointer by D-2. Only meaningful for D >= 3; shorter
    // delays never select the RAM path. Wraps naturally modulo the depth.
    assign w_rd_ofs = AW'(r_delay - DW'(2));
    assign w_ra     = r_wp - w_rd_ofs;

    // Pointer, delay and epoch control. A load restarts priming without
    // touching the write pointer: stale samples are masked by the fill
    // counter rather than by clearing the RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_delay <= f_clamp(DW'(DELAY_INIT));
            r_fill  <= '0;
            r_valid <= 1'b0;
            r_wp    <= '0;
        end else begin
            r_wp <= r_wp + 1'b1;
            if (delay_ld) begin
                r_delay <= f_clamp(delay);
                r_fill  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_fill  <= w_fill_next;
                r_valid <= (w_fill_next == r_delay);
            end
        end
    end

    ram_blk_dp #(
        .AW (AW),
        .DW (CW)
    ) u_ram (
        .clk     (clk),
        .i_waddr (r_wp),
        .i_wdata (i),
        .i_raddr (w_ra),
        .o_rdata (w_ram_q)
    );

`ifdef PIPERAM_VAR_SHORT_EN
    logic [CW-1:0] r_byp1;
    logic [CW-1:0] r_byp2;

    // Two-stage shift register for delays the RAM latency cannot reach.
    always_ff @(posedge clk) begin
        r_byp1 <= i;
        r_byp2 <= r_byp1;
    end

    assign w_data = (r_delay == DW'(1)) ? r_byp1 :
                    (r_delay == DW'(2)) ? r_byp2 : w_ram_q;
`else
    assign w_data = w_ram_q;
`endif

    // Zero-fill each lane until the epoch is primed.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
        assign o[gi*WIDTH +: WIDTH] = r_valid ? w_data[gi*WIDTH +: WIDTH] : '0;
    end

    assign o_valid   = r_valid;
    assign delay_cur = r_delay;
endmodule

// File: tb/tb_piperam_var.sv
// Self-checking bench for piperam_var (4 lanes x 16 bits, MAX_DELAY 1024).
// Reference model: per-epoch history of inputs; o(t) = hist[t-D] once t >= D.
module tb_piperam_var;
    localparam int NCH  = 4;
    localparam int MAXD = 1024;
`ifdef PIPERAM_VAR_SHORT_EN
    localparam int DMIN = 1;
`else
    localparam int DMIN = 3;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [63:0]   i;
    logic [10:0]   delay;
    logic          delay_ld;
    logic [63:0]   o;
    logic          o_valid;
    logic [10:0]   delay_cur;

    int            checks = 0;
    int            errors = 0;
    int            ep     = 0;
    int            dexp   = 16;
    int            gcyc   = 0;
    logic [63:0]   hist [8192];

    piperam_var #(
        .MAX_DELAY  (MAXD),
        .WIDTH      (16),
        .CHANNELS   (NCH),
        .DELAY_INIT (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i         (i),
        .delay     (delay),
        .delay_ld  (delay_ld),
        .o         (o),
        .o_valid   (o_valid),
        .delay_cur (delay_cur)
    );

    always #5 clk = ~clk;

    function automatic int clampd(input int v);
        if (v < DMIN) return DMIN;
        if (v > MAXD) return MAXD;
        return v;
    endfunction

    // One clock cycle: check outputs for the current cycle, drive inputs,
    // advance across the edge and update the model.
    task automatic cyc(input logic rst, input logic ld, input int dly, input bit ramp);
        logic        exp_v;
        logic [63:0] exp_o;
        exp_v = (ep >= dexp);
        exp_o = 64'd0;
        if (exp_v && (ep - dexp) < 8192)
            exp_o = hist[ep - dexp];

        checks++;
        assert (o_valid === exp_v) else begin
            errors++;
            $error("FAIL o_valid ep=%0d D=%0d: got %b expected %b", ep, dexp, o_valid, exp_v);
        end
        checks++;
        assert (o === exp_o) else begin
            errors++;
            $error("FAIL o ep=%0d D=%0d: got %h expected %h", ep, dexp, o, exp_o);
        end
        checks++;
        assert (delay_cur === 11'(dexp)) else begin
            errors++;
            $error("FAIL delay_cur ep=%0d: got %0d expected %0d", ep, delay_cur, dexp);
        end

        reset    = rst;
        delay_ld = ld;
        delay    = 11'(dly);
        for (int n = 0; n < NCH; n++)
            i[n*16 +: 16] = ramp ? 16'(1000 * n + gcyc) : 16'($urandom);

        @(posedge clk);
        gcyc++;
        if (rst) begin
            dexp = clampd(16);
            ep   = 0;
        end else if (ld) begin
            dexp = clampd(dly);
            ep   = 0;
        end else begin
            if (ep < 8192)
                hist[ep] = i;
            ep++;
        end
        #1;
    endtask

    task automatic run(input int n, input bit ramp);
        repeat (n) cyc(1'b0, 1'b0, 0, ramp);
    endtask

    task automatic load(input int d);
        cyc(1'b0, 1'b1, d, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        delay_ld = 1'b0;
        delay    = '0;
        i        = '0;
        @(posedge clk);
        #1;

        // Power-up with DELAY_INIT, ramps on every lane.
        cyc(1'b1, 1'b0, 0, 1'b1);
        cyc(1'b1, 1'b0, 0, 1'b1);
        run(40, 1'b1);

        // Short delay with distinct lane ramps.
        load(7);
        run(30, 1'b1);

        // Long delay across many pointer wraps, random data.
        load(1000);
        run(5000, 1'b0);

        // Over-range request clamps to MAX_DELAY; loaded while valid.
        load(2000);
        run(1100, 1'b0);

        // Under-range and short delays.
        load(0);
        run(20, 1'b0);
        load(1);
        run(20, 1'b0);
        load(2);
        run(20, 1'b0);
        load(3);
        run(20, 1'b0);

        // Back-to-back loads, including the same value twice.
        load(5);
        load(9);
        load(9);
        run(30, 1'b0);

        // Reset and load together mid-epoch: reset wins.
        load(50);
        run(500, 1'b0);
        cyc(1'b1, 1'b1, 4, 1'b0);
        run(40, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/piperam_var.md
Name: piperam_var

Overview:
- Runtime-programmable, multi-channel RAM delay line for long pipeline alignment, e.g. matching a data path to a slow control path whose latency is only known at run time.
- Built on ram_blk_dp (2-cycle read latency) with one shared pointer pair for all channels.
- Delay is loaded at run time up to MAX_DELAY.
- o_valid flags when the output holds genuinely delayed data; until then the output is zero-filled.

Parameters:
- MAX_DELAY, 1024, largest supported delay in cycles; RAM depth = 2**$clog2(MAX_DELAY).
- WIDTH, 16, bits per channel.
- CHANNELS, 1, number of lanes packed into i/o; all lanes share one delay.
- DELAY_INIT, 16, delay in force after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i  in  CHANNELS*WIDTH  input samples, lane n at [n*WIDTH +: WIDTH]
- delay  in  $clog2(MAX_DELAY+1)  requested delay in cycles
- delay_ld  in  1  single-cycle strobe; loads delay and restarts priming
- o  out  CHANNELS*WIDTH  delayed samples
- o_valid  out  1  high when o equals a real delayed input
- delay_cur  out  $clog2(MAX_DELAY+1)  delay actually in force, after clamping

Behaviour:
- Reset: clk and reset only; reset is synchronous, active-high.
- Reset values: o=0, o_valid=0, delay_cur=clamp(DELAY_INIT). Pointers, fill counter and wr_valid are cleared. RAM contents are not cleared.
- Clamping: D = clamp(delay) into [DMIN, MAX_DELAY]. DMIN = 3 without the optional feature, 1 with it. Clamping is applied at load; delay_cur reports D.
- Epoch start: the first cycle after reset deasserts, or the cycle after the delay_ld edge, is cycle 0 of an epoch.
- Timing contract: within an epoch, o(t) = i(t-D) for all t >= D, and o_valid(t) = 1 for t >= D.
- Priming: for t < D, o = 0 and o_valid = 0. Stale RAM data must never reach o.
- Pointers: write pointer increments every cycle and wraps modulo RAM depth. Read address is issued 2 cycles ahead of output and equals the write address used D cycles earlier. Pointer arithmetic is modulo 2**ADDRWIDTH and correct across wrap.
- Fill counter: saturates at D and drives o_valid. Width is $clog2(MAX_DELAY+1).
- delay_ld at any time, including while o_valid = 1:
  - o_valid drops the following cycle;
  - a new epoch starts;
  - samples already in flight are discarded, so o = 0 until re-primed.
- Repeated loads: delay_ld on consecutive cycles restarts the epoch each time. Loading the same value also restarts.
- Loads during reset: delay_ld while reset is high is ignored; reset wins.
- Reset mid-epoch: behaves exactly like power-up with DELAY_INIT.
- Lanes: all lanes are delayed identically, with no per-lane skew.
- Tracking: no backpressure and no clock enable. The block samples i every cycle.

Optional Feature:
- Macro: PIPERAM_VAR_SHORT_EN.
- Defined: adds a 2-stage register bypass so D = 1 and D = 2 are supported, both fully registered. DMIN = 1. For D <= 2 the output comes from the bypass regs; for D >= 3 it comes from the RAM path. Timing contract and o_valid rules are unchanged.
- Undefined: no bypass logic is built. DMIN = 3, so requests of 0..2 clamp to 3 and delay_cur reads 3.

Test Plan:
- Reset with DELAY_INIT=16, i = cycle count from cycle 0 -> o_valid rises at cycle 16 with o=0; o=0 with o_valid=0 before that; o(t) = t-16 thereafter.
- Load delay=1000 (MAX_DELAY=1024) while running -> o_valid low for cycles 0..999 of the new epoch; o(1000) = i(epoch cycle 0); correct across pointer wrap over 5000 cycles.
- Load delay=2000 -> delay_cur=1024. Load delay=0 without the macro -> delay_cur=3 and o_valid rises at epoch cycle 3.
- With PIPERAM_VAR_SHORT_EN: D=1, then D=2, then D=3 -> o(t) = i(t-D) in each case; o_valid rises at epoch cycle D.
- CHANNELS=4, lanes driven with distinct ramps (lane n = 1000*n + t), D=7 -> each lane delayed by 7 with no cross-lane corruption.
- Assert reset mid-epoch at cycle 500 and delay_ld simultaneously -> reset wins: delay_cur = DELAY_INIT, o = 0, o_valid = 0; priming restarts after release.
